// File: rtl/cpu_trace_pkg.sv
// rtl/cpu_trace_pkg.sv - shared state encoding and record layout for the trace monitor
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } trace_state_e;

  localparam int DEFAULT_CYCLE_LIMIT = 100000;

  // Record bit offsets, LSB first: mem_data, mem_addr, mem_write, mem_read,
  // write_data, write_reg, reg_write, halt.
  function automatic int off_mem_data();
    return 0;
  endfunction

  function automatic int off_mem_addr(input int dw);
    return dw;
  endfunction

  function automatic int off_mem_write(input int dw);
    return 2 * dw;
  endfunction

  function automatic int off_mem_read(input int dw);
    return 2 * dw + 1;
  endfunction

  function automatic int off_write_data(input int dw);
    return 2 * dw + 2;
  endfunction

  function automatic int off_write_reg(input int dw);
    return 3 * dw + 2;
  endfunction

  function automatic int off_reg_write(input int dw, input int rw);
    return 3 * dw + 2 + rw;
  endfunction

  function automatic int off_halt(input int dw, input int rw);
    return 3 * dw + 3 + rw;
  endfunction

  function automatic int rec_width(input int dw, input int rw);
    return 3 * dw + 4 + rw;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - single-clock FIFO with wrap-bit pointers; storage is not reset
module trace_fifo #(
  parameter int WIDTH = 56,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign pop_data = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cpu_trace_monitor.sv
// rtl/cpu_trace_monitor.sv - retirement/memory trace monitor: FSM, counters, record capture
module cpu_trace_monitor
  import cpu_trace_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int REG_W       = 4,
  parameter int CNT_W       = 32,
  parameter int DEPTH       = 8,
  parameter int CYCLE_LIMIT = DEFAULT_CYCLE_LIMIT
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic                                  reg_write,
  input  logic [REG_W-1:0]                      write_reg,
  input  logic [DATA_W-1:0]                     write_data,
  input  logic                                  mem_read,
  input  logic                                  mem_write,
  input  logic [DATA_W-1:0]                     mem_addr,
  input  logic [DATA_W-1:0]                     mem_wdata,
  input  logic [DATA_W-1:0]                     mem_rdata,
  input  logic                                  halt,
  output logic                                  trace_valid,
  input  logic                                  trace_ready,
  output logic [rec_width(DATA_W, REG_W)-1:0]   trace_rec,
  output logic [CNT_W-1:0]                      cycle_count,
  output logic [CNT_W-1:0]                      inst_count,
  output logic [CNT_W-1:0]                      drop_count,
  output logic [1:0]                            state,
  output logic                                  done
);

  localparam int REC_W = rec_width(DATA_W, REG_W);
  localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(CYCLE_LIMIT);

  trace_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  inst_q, inst_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [REC_W-1:0]  rec;
  logic              running;
  logic              evt;
  logic              push;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == '1) ? x : x + CNT_W'(1);
  endfunction

  assign running = (state_q == ST_RUN);
  assign evt     = halt | reg_write | mem_read | mem_write;
  assign push    = running & evt;
  // Full implies non-empty, so a ready sink always frees a slot this edge.
  assign drop    = push & fifo_full & ~trace_ready;

  always_comb begin
    rec = '0;
    rec[off_halt(DATA_W, REG_W)]                = halt;
    rec[off_reg_write(DATA_W, REG_W)]           = reg_write;
    rec[off_write_reg(DATA_W) +: REG_W]         = write_reg;
    rec[off_write_data(DATA_W) +: DATA_W]       = write_data;
    rec[off_mem_read(DATA_W)]                   = mem_read;
    rec[off_mem_write(DATA_W)]                  = mem_write;
    rec[off_mem_addr(DATA_W) +: DATA_W]         = mem_addr;
    rec[off_mem_data() +: DATA_W]               = mem_write ? mem_wdata : mem_rdata;
  end

  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    inst_d  = inst_q;
    drop_d  = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        cycle_d = sat_inc(cycle_q);
        if (halt | reg_write | mem_write) inst_d = sat_inc(inst_q);
        if (drop) drop_d = sat_inc(drop_q);
        if (halt)
          state_d = ST_HALTED;
        else if (({1'b0, cycle_q} + (CNT_W+1)'(1)) == LIMIT)
          state_d = ST_TIMEOUT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cycle_q <= '0;
      inst_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      inst_q  <= inst_d;
      drop_q  <= drop_d;
    end
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (rec),
    .pop       (trace_ready),
    .pop_data  (trace_rec),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign trace_valid = ~fifo_empty;
  assign cycle_count = cycle_q;
  assign inst_count  = inst_q;
  assign drop_count  = drop_q;
  assign state       = state_q;
  assign done        = ((state_q == ST_HALTED) || (state_q == ST_TIMEOUT)) && fifo_empty;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// tb/tb_cpu_trace_monitor.sv - scoreboard bench for cpu_trace_monitor
module tb_cpu_trace_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        reg_write;
  logic [3:0]  write_reg;
  logic [15:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        halt;
  logic        trace_valid;
  logic        trace_ready;
  logic [55:0] trace_rec;
  logic [31:0] cycle_count;
  logic [31:0] inst_count;
  logic [31:0] drop_count;
  logic [1:0]  state;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [55:0] sb[$];

  cpu_trace_monitor #(
    .DATA_W      (16),
    .REG_W       (4),
    .CNT_W       (32),
    .DEPTH       (8),
    .CYCLE_LIMIT (50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .halt        (halt),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_rec   (trace_rec),
    .cycle_count (cycle_count),
    .inst_count  (inst_count),
    .drop_count  (drop_count),
    .state       (state),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic logic [55:0] mk(input logic h, input logic rw, input logic [3:0] wr,
                                     input logic [15:0] wd, input logic mr, input logic mw,
                                     input logic [15:0] ma, input logic [15:0] md);
    return {h, rw, wr, wd, mr, mw, ma, md};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ev();
    reg_write  = 1'b0;
    write_reg  = '0;
    write_data = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_rdata  = '0;
    halt       = 1'b0;
  endtask

  task automatic do_reset();
    clr_ev();
    en  = 1'b0;
    rst = 1'b1;
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start();
    en = 1'b1;
    tick();
  endtask

  task automatic store(input logic [15:0] addr, input logic [15:0] data, input logic expect_push);
    mem_write = 1'b1;
    mem_addr  = addr;
    mem_wdata = data;
    mem_rdata = 16'hFFFF;
    if (expect_push) sb.push_back(mk(1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1, addr, data));
    tick();
  endtask

  // Monitor: the head must match the scoreboard whenever valid; pop on handshake.
  always @(negedge clk) begin
    if (!rst && trace_valid) begin
      if (sb.size() == 0) begin
        if (trace_ready) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_record: got %h expected none", trace_rec);
        end
      end else begin
        n_checks++;
        if (trace_rec !== sb[0]) begin
          n_fail++;
          $display("FAIL trace_rec: got %h expected %h", trace_rec, sb[0]);
        end
        if (trace_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    trace_ready = 1'b1;
    clr_ev();
    en  = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // reset and start
    repeat (5) tick();
    chk("idle_state", state, 0);
    chk("idle_cycle", cycle_count, 0);
    chk("idle_inst", inst_count, 0);
    chk("idle_drop", drop_count, 0);
    chk("idle_valid", trace_valid, 0);
    chk("idle_done", done, 0);
    start();
    chk("run_state", state, 1);
    chk("run_cycle0", cycle_count, 0);
    repeat (3) tick();
    chk("run_cycle3", cycle_count, 3);

    // combined register write + load
    reg_write  = 1'b1;
    write_reg  = 4'd3;
    write_data = 16'h1234;
    mem_read   = 1'b1;
    mem_addr   = 16'h0040;
    mem_rdata  = 16'hBEEF;
    sb.push_back(mk(1'b0, 1'b1, 4'd3, 16'h1234, 1'b1, 1'b0, 16'h0040, 16'hBEEF));
    tick();
    clr_ev();
    chk("comb_inst", inst_count, 1);
    chk("comb_cycle", cycle_count, 4);
    chk("comb_valid", trace_valid, 1);
    tick();
    chk("comb_drained_valid", trace_valid, 0);
    chk("comb_drained_sb", sb.size(), 0);

    // backpressure: 10 stores into 8 entries
    do_reset();
    start();
    trace_ready = 1'b0;
    for (int i = 0; i < 10; i++) store(16'h0100 + 16'(i), 16'(i), i < 8);
    clr_ev();
    chk("bp_drop", drop_count, 2);
    chk("bp_inst", inst_count, 10);
    chk("bp_cycle", cycle_count, 10);
    chk("bp_valid", trace_valid, 1);
    trace_ready = 1'b1;
    repeat (8) tick();
    chk("bp_drain_valid", trace_valid, 0);
    chk("bp_drain_sb", sb.size(), 0);

    // full plus pop on the same edge
    do_reset();
    start();
    trace_ready = 1'b0;
    for (int i = 0; i < 8; i++) store(16'h0200 + 16'(i), 16'h0020 + 16'(i), 1'b1);
    trace_ready = 1'b1;
    store(16'h02AA, 16'h00AA, 1'b1);
    trace_ready = 1'b0;
    clr_ev();
    chk("fp_no_drop", drop_count, 0);
    store(16'h02BB, 16'h00BB, 1'b0);
    clr_ev();
    chk("fp_still_full_drop", drop_count, 1);
    chk("fp_inst", inst_count, 10);
    trace_ready = 1'b1;
    repeat (8) tick();
    chk("fp_drain_valid", trace_valid, 0);
    chk("fp_drain_sb", sb.size(), 0);

    // halt on RUN cycle 20
    do_reset();
    start();
    trace_ready = 1'b0;
    repeat (4) tick();
    reg_write  = 1'b1;
    write_reg  = 4'd5;
    write_data = 16'h5555;
    sb.push_back(mk(1'b0, 1'b1, 4'd5, 16'h5555, 1'b0, 1'b0, 16'h0, 16'h0));
    tick();
    clr_ev();
    repeat (14) tick();
    chk("halt_pre_cycle", cycle_count, 19);
    halt = 1'b1;
    sb.push_back(mk(1'b1, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0));
    tick();
    chk("halt_state", state, 2);
    chk("halt_cycle", cycle_count, 20);
    chk("halt_inst", inst_count, 2);
    chk("halt_done_pending", done, 0);
    reg_write = 1'b1;
    repeat (3) tick();
    chk("halt_frozen_cycle", cycle_count, 20);
    chk("halt_frozen_inst", inst_count, 2);
    chk("halt_frozen_state", state, 2);
    clr_ev();
    trace_ready = 1'b1;
    repeat (3) tick();
    chk("halt_drain_sb", sb.size(), 0);
    chk("halt_done", done, 1);

    // timeout at CYCLE_LIMIT
    do_reset();
    start();
    repeat (49) tick();
    chk("to_pre_state", state, 1);
    chk("to_pre_cycle", cycle_count, 49);
    tick();
    chk("to_state", state, 3);
    chk("to_cycle", cycle_count, 50);
    chk("to_done", done, 1);
    repeat (3) tick();
    chk("to_frozen_cycle", cycle_count, 50);
    chk("to_frozen_state", state, 3);

    // halt wins on the limit edge
    do_reset();
    start();
    repeat (49) tick();
    halt = 1'b1;
    sb.push_back(mk(1'b1, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0));
    tick();
    clr_ev();
    chk("hw_state", state, 2);
    chk("hw_cycle", cycle_count, 50);
    chk("hw_inst", inst_count, 1);
    tick();
    chk("hw_done", done, 1);
    chk("hw_drain_sb", sb.size(), 0);

    // asynchronous reset mid-run
    do_reset();
    start();
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(16'h0300 + 16'(i), 16'h0030 + 16'(i), 1'b1);
    clr_ev();
    chk("mr_pre_cycle", cycle_count, 3);
    chk("mr_pre_valid", trace_valid, 1);
    en = 1'b0;
    #3;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("mr_state", state, 0);
    chk("mr_cycle", cycle_count, 0);
    chk("mr_inst", inst_count, 0);
    chk("mr_valid", trace_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("mr_post_state", state, 0);
    chk("mr_post_drop", drop_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
